uart_rx_framed: RTL

Parametrised successor to the team's fixed-format UART receiver. It oversamples the line, majority-votes each bit, and supports 5–9 data bits, optional parity, and 1 or 2 stop bits. Received words leave through a valid/ready handshake with per-word framing, parity and overrun status. It sits between the pin-level `rx` input and any word-consuming logic, such as a FIFO or command decoder, in the `clk` domain.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sample_tick.sv | 39 +++
 rtl/uart_rx_framed.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the oversampling UART receiver.
//   rxState_t : receiver state encoding (3 bits)
//   uart_div  : clocks per sample tick, integer division of the clock rate by
//               (baud rate * oversample factor)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rxState_t;

    function automatic int uart_div(input int clockRate, input int baudRate, input int oversample);
        return clockRate / (baudRate * oversample);
    endfunction

endpackage

// File: rtl/uart_sample_tick.sv
// -----------------------------------------------------------------------------
// uart_sample_tick
// Free-running divide-by-DIV counter that produces a one-clock sample tick.
// A synchronous restart zeroes the count so that the first tick after a
// restart arrives exactly DIV clocks later.
//
// Ports
//   clk     in  : system clock, rising edge
//   rstN    in  : asynchronous active-low reset
//   restart in  : synchronous restart of the divider
//   tick    out : one-clock pulse every DIV clocks (suppressed on restart)
// -----------------------------------------------------------------------------
module uart_sample_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rstN,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_framed.sv
// -----------------------------------------------------------------------------
// uart_rx_framed
// Oversampling UART receiver with majority-voted bits, 5..9 data bits,
// optional parity and 1 or 2 stop bits. Received words are offered on a
// valid/ready handshake together with frame-error and parity-error flags;
// a word that completes while the previous one is still held is dropped and
// reported with a one-clock overrun pulse.
//
// Build option
//   UART_RX_PARITY_EN : when defined, each frame carries one parity bit
//                       (even when PARITY_ODD=0, odd when PARITY_ODD=1) and
//                       parityErr reports mismatches. When undefined the
//                       frame has no parity bit and parityErr is tied to 0.
//
// Ports
//   clk       in  : system clock, rising edge
//   rstN      in  : asynchronous active-low reset
//   rx        in  : serial line, asynchronous, idle high
//   rxData    out : received word, stable while rxValid=1
//   rxValid   out : word available
//   rxReady   in  : consumer accepts the word when rxValid && rxReady
//   frameErr  out : a stop bit of this word sampled 0 (qualified by rxValid)
//   parityErr out : parity mismatch on this word (qualified by rxValid)
//   overrun   out : one-clock pulse when a word is dropped
// -----------------------------------------------------------------------------
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 16_000_000,
    parameter int BAUD_RATE  = 1_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    input  logic                 rxReady,
    output logic                 frameErr,
    output logic                 parityErr,
    output logic                 overrun
);

    localparam int DIV = uart_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);

    // Sample indices inside one bit: the vote uses three samples centred on
    // the middle of the bit; the third one is also the decision point.
    localparam logic [SCW-1:0] S_VOTE0 = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] S_VOTE1 = SCW'(OVERSAMPLE / 2);
    localparam logic [SCW-1:0] S_MID   = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [SCW-1:0] S_LAST  = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] B_LAST  = BCW'(DATA_BITS);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

    // -------------------------------------------------------------------------
    // Parameter sanity checks, evaluated at elaboration.
    // -------------------------------------------------------------------------
    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_rx_framed: CLOCK_RATE must be at least BAUD_RATE*OVERSAMPLE");
        end
        if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
            $error("uart_rx_framed: OVERSAMPLE must be even and at least 8");
        end
        if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_db
            $error("uart_rx_framed: DATA_BITS must be 5..9");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_sb
            $error("uart_rx_framed: STOP_BITS must be 1 or 2");
        end
        if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_par
            $error("uart_rx_framed: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Line synchroniser. Flops reset to the idle level so that reset release
    // never looks like a start edge.
    // -------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_rxs;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // -------------------------------------------------------------------------
    // Sample tick
    // -------------------------------------------------------------------------
    logic w_tick;
    logic w_restart;

    uart_sample_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk     (clk),
        .rstN    (rstN),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // -------------------------------------------------------------------------
    // Receiver state and datapath registers
    // -------------------------------------------------------------------------
    rxState_t              r_state;
    rxState_t              w_state_next;
    logic [SCW-1:0]        r_sample_cnt;
    logic [BCW-1:0]        r_bit_cnt;
    logic                  r_stop_cnt;
    logic                  r_vote0;
    logic                  r_vote1;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_ferr;

    logic                  r_rx_valid;
    logic [DATA_BITS-1:0]  r_rx_data;
    logic                  r_frame_err;
    logic                  r_overrun;

    logic w_vote;
    logic w_at_mid;
    logic w_at_end;
    logic w_in_frame;
    logic w_shift_en;
    logic w_stop_mid;
    logic w_stop_adv;
    logic w_commit;
    logic w_ferr_final;

    // Majority of the two stored samples and the live sample at mid.
    assign w_vote   = (r_vote0 & r_vote1) | (r_vote0 & w_rxs) | (r_vote1 & w_rxs);
    assign w_at_mid = w_tick && (r_sample_cnt == S_MID);
    assign w_at_end = w_tick && (r_sample_cnt == S_LAST);

    assign w_in_frame = (r_state == START) || (r_state == DATA) ||
                        (r_state == PARITY) || (r_state == STOP);

    // The committed frame-error flag includes the vote of the last stop bit,
    // which is being decided in the commit cycle itself.
    assign w_ferr_final = r_ferr | ~w_vote;

`ifdef UART_RX_PARITY_EN
    logic w_par_chk;
    logic w_par_exp;
    logic r_perr;
    logic r_parity_err;

    // Even parity: the parity bit equals the XOR of the data bits.
    assign w_par_exp = (^r_shift) ^ PARITY_ODD[0];
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and control strobes
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_shift_en   = 1'b0;
        w_stop_mid   = 1'b0;
        w_stop_adv   = 1'b0;
        w_commit     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_chk    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_next = START;
                    w_restart    = 1'b1;
                end
            end
            START: begin
                // A start bit that votes high was only a glitch.
                if (w_at_mid && w_vote) begin
                    w_state_next = IDLE;
                end else if (w_at_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_at_mid) begin
                    w_shift_en = 1'b1;
                end
                // The bit counter is bumped at mid, so it already reads
                // DATA_BITS by the end of the final data bit.
                if (w_at_end && (r_bit_cnt == B_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_at_mid) begin
                    w_par_chk = 1'b1;
                end
                if (w_at_end) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_at_mid) begin
                    w_stop_mid = 1'b1;
                    // Leaving at mid of the last stop bit gives half a bit
                    // of slack before the next start edge.
                    if (r_stop_cnt == STOP_LAST) begin
                        w_commit     = 1'b1;
                        w_state_next = w_ferr_final ? BREAK : IDLE;
                    end
                end
                if (w_at_end) begin
                    w_stop_adv = 1'b1;
                end
            end
            BREAK: begin
                // Wait for the line to return high so a held-low line does
                // not produce a stream of zero words.
                if (w_rxs) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sampling, shifting and error accumulation
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_vote0      <= 1'b0;
            r_vote1      <= 1'b0;
            r_shift      <= '0;
            r_ferr       <= 1'b0;
        end else begin
            if (w_restart) begin
                r_sample_cnt <= '0;
                r_bit_cnt    <= '0;
                r_stop_cnt   <= 1'b0;
                r_ferr       <= 1'b0;
            end else begin
                if (w_tick && w_in_frame) begin
                    r_sample_cnt <= (r_sample_cnt == S_LAST) ? '0 : (r_sample_cnt + SCW'(1));
                    if (r_sample_cnt == S_VOTE0) begin
                        r_vote0 <= w_rxs;
                    end
                    if (r_sample_cnt == S_VOTE1) begin
                        r_vote1 <= w_rxs;
                    end
                end
                if (w_shift_en) begin
                    // LSB arrives first: shift in from the top.
                    r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                    r_bit_cnt <= r_bit_cnt + BCW'(1);
                end
                if (w_stop_mid) begin
                    r_ferr <= w_ferr_final;
                end
                if (w_stop_adv) begin
                    r_stop_cnt <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_perr <= 1'b0;
        end else if (w_restart) begin
            r_perr <= 1'b0;
        end else if (w_par_chk) begin
            r_perr <= (w_vote != w_par_exp);
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Output word register and handshake
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_overrun <= 1'b0;
            if (w_commit) begin
                // A word being accepted in this very cycle frees the slot.
                if (!r_rx_valid || rxReady) begin
                    r_rx_valid   <= 1'b1;
                    r_rx_data    <= r_shift;
                    r_frame_err  <= w_ferr_final;
`ifdef UART_RX_PARITY_EN
                    r_parity_err <= r_perr;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rxReady) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rxValid  = r_rx_valid;
    assign rxData   = r_rx_data;
    assign frameErr = r_frame_err;
    assign overrun  = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parityErr = r_parity_err;
`else
    assign parityErr = 1'b0;
`endif

endmodule
